// File: rtl/reg_fifo_pkg.sv
// Shared width helpers for the reg_fifo buffer register and its control block.
package reg_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_fifo_ctrl.sv
// Pointer, occupancy and flag control for reg_fifo; all state moves on the falling clock edge.
module reg_fifo_ctrl
  import reg_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             push_acc,
  output logic [PTR_W-1:0] wp,
  output logic [PTR_W-1:0] rp,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overrun
);

  logic pop_acc;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop frees the slot the same-cycle push needs, so a full buffer still takes both.
  always_comb begin
    pop_acc  = 1'b0;
    push_acc = 1'b0;
    if (!clear) begin
      pop_acc  = rd_en && !empty;
      push_acc = wr_en && (!full || pop_acc);
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (clear) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_acc) wp <= wp + 1'b1;
      if (pop_acc)  rp <= rp + 1'b1;
      count <= count + CNT_W'(push_acc) - CNT_W'(pop_acc);
      if (wr_en && !push_acc) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_fifo.sv
// First-word-fall-through buffer register: storage array plus head-word mux.
module reg_fifo
  import reg_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] d,
  input  logic             rd_en,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overrun
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             push_acc;

  reg_fifo_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .push_acc(push_acc),
    .wp      (wp),
    .rp      (rp),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .overrun (overrun)
  );

  // Contents are don't-care after reset/clear, so the array carries no reset.
  always_ff @(negedge clock) begin
    if (push_acc) mem[wp] <= d;
  end

  assign q = empty ? RESET_VALUE : mem[rp];

endmodule

// File: tb/tb_reg_fifo.sv
// Scoreboard bench for reg_fifo (WIDTH=8, DEPTH=4, RESET_VALUE=FF).
module tb_reg_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] d     = '0;
  logic [7:0] q;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overrun;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [7:0] sb [$];
  logic       m_ovr = 1'b0;

  reg_fifo #(
    .WIDTH(8),
    .DEPTH(4),
    .RESET_VALUE(8'hFF)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .wr_en  (wr_en),
    .d      (d),
    .rd_en  (rd_en),
    .q      (q),
    .empty  (empty),
    .full   (full),
    .count  (count),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_q;
    exp_q = (sb.size() == 0) ? 8'hFF : sb[0];
    check({tag, ".q"},       q,       exp_q);
    check({tag, ".count"},   count,   sb.size());
    check({tag, ".empty"},   empty,   sb.size() == 0);
    check({tag, ".full"},    full,    sb.size() == 4);
    check({tag, ".overrun"}, overrun, m_ovr);
  endtask

  // One falling edge with the given request; model updated afterwards.
  task automatic cycle(input string tag, input logic wr, input logic rd,
                       input logic clr, input logic [7:0] data);
    logic pop, push;
    if (rd && !clr && sb.size() > 0) check({tag, ".pop_q"}, q, sb[0]);
    wr_en = wr; rd_en = rd; clear = clr; d = data;
    @(negedge clock);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    if (clr) begin
      sb.delete();
      m_ovr = 1'b0;
    end else begin
      pop  = rd && (sb.size() > 0);
      push = wr && ((sb.size() < 4) || pop);
      if (wr && !push) m_ovr = 1'b1;
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(data);
    end
    check_state(tag);
  endtask

  initial begin
    #3;
    check_state("reset_async");
    @(negedge clock);
    #1;
    reset = 1'b0;
    cycle("idle", 1'b0, 1'b0, 1'b0, 8'h00);

    cycle("fill11", 1'b1, 1'b0, 1'b0, 8'h11);
    cycle("fill22", 1'b1, 1'b0, 1'b0, 8'h22);
    cycle("fill33", 1'b1, 1'b0, 1'b0, 8'h33);
    cycle("fill44", 1'b1, 1'b0, 1'b0, 8'h44);
    cycle("ovr55",  1'b1, 1'b0, 1'b0, 8'h55);
    check("ovr_flag", overrun, 1'b1);
    for (int i = 0; i < 4; i++) cycle("drain1", 1'b0, 1'b1, 1'b0, 8'h00);
    check("drain1_empty", empty, 1'b1);

    cycle("clr0", 1'b0, 1'b0, 1'b1, 8'h00);
    cycle("f2_11", 1'b1, 1'b0, 1'b0, 8'h11);
    cycle("f2_22", 1'b1, 1'b0, 1'b0, 8'h22);
    cycle("f2_33", 1'b1, 1'b0, 1'b0, 8'h33);
    cycle("f2_44", 1'b1, 1'b0, 1'b0, 8'h44);
    cycle("full_pp66", 1'b1, 1'b1, 1'b0, 8'h66);
    check("pp66_q", q, 8'h22);
    for (int i = 0; i < 4; i++) cycle("drain2", 1'b0, 1'b1, 1'b0, 8'h00);

    cycle("empty_pp77", 1'b1, 1'b1, 1'b0, 8'h77);
    check("pp77_q", q, 8'h77);
    cycle("pop77", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("pop_empty", 1'b0, 1'b1, 1'b0, 8'h00);

    cycle("h_a1", 1'b1, 1'b0, 1'b0, 8'hA1);
    cycle("h_a2", 1'b1, 1'b0, 1'b0, 8'hA2);
    cycle("h_a3", 1'b1, 1'b0, 1'b0, 8'hA3);
    cycle("h_a4", 1'b1, 1'b0, 1'b0, 8'hA4);
    cycle("h_ovr", 1'b1, 1'b0, 1'b0, 8'hA5);
    cycle("h_pop", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("clear88", 1'b1, 1'b0, 1'b1, 8'h88);
    check("clear88_q", q, 8'hFF);

    cycle("r_b1", 1'b1, 1'b0, 1'b0, 8'hB1);
    cycle("r_b2", 1'b1, 1'b0, 1'b0, 8'hB2);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    m_ovr = 1'b0;
    check_state("reset_mid");
    #1;
    reset = 1'b0;
    cycle("push99", 1'b1, 1'b0, 1'b0, 8'h99);
    check("push99_q", q, 8'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_fifo.md
# reg_fifo

Parametrised first-word-fall-through buffer register, WIDTH bits wide and DEPTH entries deep. It buffers bytes between the CPU-side register interface and the MIDI serial engines, typically as the receive holding register with overrun detection. All state updates on the falling edge of `clock`, the same edge used by the existing single-entry holding registers, so it drops into the same datapath without retiming. DEPTH=1 is not supported; the single-entry holding register covers that case.

## Interface
- `WIDTH`, 8, data word width in bits (≥1).
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `RESET_VALUE`, 0, value driven on `q` whenever the buffer is empty.
- `clock`  in  1  update clock; all state changes on its falling edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `clear`  in  1  synchronous flush; sampled on the falling edge.
- `wr_en`  in  1  push request.
- `d`  in  WIDTH  push data.
- `rd_en`  in  1  pop request; acknowledges the word currently on `q`.
- `q`  out  WIDTH  head word (FWFT); equals `RESET_VALUE` when empty.
- `empty`  out  1  no words held.
- `full`  out  1  DEPTH words held.
- `count`  out  $clog2(DEPTH)+1  number of words held, 0..DEPTH.
- `overrun`  out  1  sticky: a push was dropped because the buffer was full.

## Operation
- Storage: DEPTH×WIDTH array, write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, wrapping DEPTH-1 → 0. `count` is held as a separate register; `empty` = (count==0) and `full` = (count==DEPTH), both decoded from `count`.
- Priority on each falling edge: `reset` (async) > `clear` > push/pop.
- `clear`: `wp`=`rp`=0, `count`=0, `overrun`=0. Any push or pop in the same cycle is ignored. Array contents are don't-care.
- Push accepted when `wr_en` and (!`full` or pop accepted in the same cycle). The word is written to mem[`wp`] and `wp` increments.
- Push when `full` without a pop: the word is dropped and `overrun` is set to 1. `count` and the pointers are unchanged.
- Pop accepted when `rd_en` and !`empty`. `rp` increments. Pop when `empty` is ignored silently; no flag is raised.
- Simultaneous push and pop:
  - Not empty: both are accepted and `count` is unchanged. This includes the full case; no overrun is flagged.
  - Empty: the push is accepted and the pop is ignored, so `count` becomes 1.
- `count` next = count + push_acc − pop_acc.
- `q` = mem[`rp`] when !`empty`, else `RESET_VALUE`. This is a combinational read of the registered array and pointer.
- `overrun` clears only on `reset` or `clear`.

## Timing
- Reset values, applied immediately on `reset` rising without waiting for a clock edge: `q`=`RESET_VALUE`, `empty`=1, `full`=0, `count`=0, `overrun`=0, `wp`=`rp`=0.
- Reset deassertion takes effect at the first falling edge that follows.
- Push latency: a word pushed into an empty buffer at falling edge N appears on `q` immediately after edge N, with `empty`=0 after edge N.
- Pop: after edge N, `q` shows the next word, or `RESET_VALUE` if that pop emptied the buffer.
- `full`, `empty`, `count` and `overrun` all reflect the state after the most recent falling edge.
- Inputs must be stable around the falling edge; the rising edge has no effect.
- `reset` asserted mid-operation discards all buffered data and sets `overrun` to 0.

## Structure
- Shared package holds `PTR_W` = $clog2(DEPTH) and `CNT_W` = PTR_W+1 as derived-width helpers. No typedefs are needed.
- One sub-module, `reg_fifo_ctrl`, contains the pointers, `count`, the flags and the accept logic. The top level holds the storage array and the `q` mux.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, RESET_VALUE=8'hFF.
- Reset, then no activity → `q`=FF, `empty`=1, `full`=0, `count`=0, `overrun`=0.
- Push 11, 22, 33, 44 on consecutive edges → `full`=1, `count`=4, `q`=11. Push 55 → `overrun`=1, `count`=4. Pop four times → `q` shows 22, 33, 44, then FF, ending with `empty`=1. Value 55 never appears.
- Fill to 4, then simultaneous push 66 and pop → `count`=4, `overrun`=0, `q`=22. Draining yields 22, 33, 44, 66, which confirms pointer wrap-around.
- Empty buffer, simultaneous push 77 and pop → `count`=1, `q`=77.
- Pop on an empty buffer → no state change.
- Hold 3 words with `overrun`=1, then assert `clear` together with push 88 → `count`=0, `overrun`=0, `q`=FF, and 88 is discarded.
- Push 2 words, then pulse `reset` between clock edges → outputs return to their reset values immediately. The next push of 99 gives `q`=99 and `count`=1.
